alu_exec_pipe: RTL
==================

# alu_exec_pipe

Two-register execute pipeline wrapped around the combinational 32-bit ALU. It accepts decoded instructions from the decode stage over a valid/ready handshake, resolves operand hazards by forwarding, drives the ALU operand and control pins from its ID/EX register, and captures the ALU result into an EX/MEM register handed to the memory stage over a second valid/ready handshake.

## Interface
- XLEN, 32, datapath width; ALU pins are XLEN wide.
- RA_W, 5, register-address width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active low.
- flush  in  1  synchronous kill of the ID/EX entry and the incoming decode beat.
- id_valid / id_ready  in / out  1  decode-side handshake.
- id_ctrl  in  3  ALU operation code (000 add … 111 pass).
- id_rs1, id_rs2  in  RA_W  source register numbers.
- id_rs1_val, id_rs2_val  in  XLEN  register-file read data.
- id_imm  in  XLEN  immediate; id_use_imm  in  1  selects id_imm for operand B.
- id_rd  in  RA_W; id_rd_we  in  1  destination and write enable.
- wb_we  in  1; wb_rd  in  RA_W; wb_val  in  XLEN  writeback forwarding port.
- alu_a, alu_b  out  XLEN; alu_ctrl  out  3  ALU drive, straight from ID/EX register.
- alu_c  in  XLEN; alu_cout  in  1  ALU result.
- ex_valid  out  1; ex_ready  in  1  memory-side handshake.
- ex_result  out  XLEN; ex_cout  out  1; ex_rd  out  RA_W; ex_rd_we  out  1.

## Operation
- Stage S1 (ID/EX): v1, ctrl1, a1, b1, rd1, we1. Stage S2 (EX/MEM): v2, res2, cout2, rd2, we2.
- Enables: en2 = !v2 | ex_ready; en1 = !v1 | en2; id_ready = en1 & !flush.
- Decode beat accepted when id_valid & id_ready; on acceptance S1 loads forwarded operands, else if en1, v1 <= 0.
- S1 -> S2 move when en2: v2 <= v1, res2 <= alu_c, rd2/we2 copied; cout2 <= alu_cout for ctrl1 in {000,001,111}, else 0 (ALU leaves cout undriven for logic/compare ops; never propagate Z/X).
- When en2 and !v1, v2 <= 0; data registers may hold.
- Forwarding per source (rs1 -> a1, rs2 -> b1 unless id_use_imm, then b1 = id_imm), first match wins:
  1. v1 & we1 & rd1 == rs & rs != 0 -> alu_c (S1 leaves this same cycle, guaranteed since en1 & v1 implies en2).
  2. v2 & we2 & rd2 == rs & rs != 0 -> res2.
  3. wb_we & wb_rd == rs & rs != 0 -> wb_val.
  4. otherwise register-file value. Register 0 never forwarded.
- Forwarding from S2 while S2 is stalled is legal: S2 holds its value until the beat leaves.
- flush: v1 <= 0 at the edge, incoming beat dropped (id_ready low that cycle); S2 and its handshake unaffected.
- ex_valid = v2; ex_result/ex_cout/ex_rd/ex_rd_we = S2 registers; held stable while ex_valid & !ex_ready.
- alu_a = a1, alu_b = b1, alu_ctrl = ctrl1 at all times (valid or not).

## Timing
- Reset (rst_n low, immediately): v1 = v2 = 0, all data registers 0; outputs ex_valid 0, id_ready 1 after release, alu_ctrl 000, alu_a/alu_b/ex_* 0.
- Latency: beat accepted at edge N -> ex_valid high after edge N+1 (2 cycles); throughput 1 beat/cycle with ex_ready held high.
- Back-pressure: ex_ready low with v2 set stalls S2; if v1 also set, id_ready drops combinationally in the same cycle. Recovery: id_ready rises the cycle ex_ready rises.
- No combinational path from id_valid to id_ready; ex_ready -> id_ready path is combinational (two AND levels).
- Reset asserted mid-stall discards both entries; no partial beat emitted.

## Test plan
- Reset: hold rst_n low, drive id_valid 1 -> ex_valid 0, alu_ctrl 000, id_ready 1 on release; first beat appears only after release.
- Back-to-back dependency: add r1 = 5+7, then add r2 = r1+r1 (rs val stale 0) -> results 12 then 24, one per cycle, ex_valid continuous.
- Stall: ex_ready low 3 cycles with two beats in flight -> id_ready low, ex_result held 12 unchanged, both beats emerge in order after ex_ready rises; no duplicates.
- Priority and x0: S2 holds rd=3 value 9, wb writes rd=3 value 4, new beat reads r3 -> operand 9; same pattern with rd=0 -> regfile value used.
- Cout masking: xor 0xFFFFFFFF^0x1 with alu_cout driven Z -> ex_cout 0, ex_result 0xFFFFFFFE; sub 0-1 -> ex_cout 0, result 0xFFFFFFFF.
- Flush: flush with S1 valid and id_valid 1 -> neither beat reaches ex_valid; older S2 beat still delivered.

Source files
------------

// File: rtl/alu_exec_pipe.sv
// Execute pipeline: ID/EX and EX/MEM registers around an external combinational ALU,
// with operand forwarding and valid/ready handshakes toward decode and memory.
module alu_exec_pipe #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [2:0]      id_ctrl,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [XLEN-1:0] id_rs1_val,
  input  logic [XLEN-1:0] id_rs2_val,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_use_imm,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_rd_we,
  input  logic            wb_we,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_val,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_c,
  input  logic            alu_cout,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_result,
  output logic            ex_cout,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_rd_we
);

  logic            v1, we1;
  logic [2:0]      ctrl1;
  logic [XLEN-1:0] a1, b1;
  logic [RA_W-1:0] rd1;
  logic            v2, cout2, we2;
  logic [XLEN-1:0] res2;
  logic [RA_W-1:0] rd2;
  logic            en1, en2, accept, cout_keep;
  logic [XLEN-1:0] op_a, op_b;

  // Youngest producer wins: the S1 entry's result is still on the ALU output this cycle.
  function automatic logic [XLEN-1:0] fwd_operand(input logic [RA_W-1:0] rs,
                                                  input logic [XLEN-1:0] rf_val);
    if (rs == '0)                    return rf_val;
    else if (v1 && we1 && rd1 == rs) return alu_c;
    else if (v2 && we2 && rd2 == rs) return res2;
    else if (wb_we && wb_rd == rs)   return wb_val;
    else                             return rf_val;
  endfunction

  always_comb begin
    en2      = !v2 || ex_ready;
    en1      = !v1 || en2;
    id_ready = en1 && !flush;
    accept   = id_valid && id_ready;
    op_a     = fwd_operand(id_rs1, id_rs1_val);
    op_b     = id_use_imm ? id_imm : fwd_operand(id_rs2, id_rs2_val);
  end

  // The ALU leaves carry undriven for logic and compare operations.
  always_comb begin
    cout_keep = 1'b0;
    case (ctrl1)
      3'b000, 3'b001, 3'b111: cout_keep = alu_cout;
      default:                cout_keep = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      ctrl1 <= '0;
      a1    <= '0;
      b1    <= '0;
      rd1   <= '0;
      we1   <= 1'b0;
    end else if (accept) begin
      v1    <= 1'b1;
      ctrl1 <= id_ctrl;
      a1    <= op_a;
      b1    <= op_b;
      rd1   <= id_rd;
      we1   <= id_rd_we;
    end else if (en1 || flush) begin
      v1    <= 1'b0;
    end
  end

  // A flushed S1 entry must not advance into S2 even when S2 is free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      res2  <= '0;
      cout2 <= 1'b0;
      rd2   <= '0;
      we2   <= 1'b0;
    end else if (en2) begin
      v2 <= v1 && !flush;
      if (v1 && !flush) begin
        res2  <= alu_c;
        cout2 <= cout_keep;
        rd2   <= rd1;
        we2   <= we1;
      end
    end
  end

  assign alu_a     = a1;
  assign alu_b     = b1;
  assign alu_ctrl  = ctrl1;
  assign ex_valid  = v2;
  assign ex_result = res2;
  assign ex_cout   = cout2;
  assign ex_rd     = rd2;
  assign ex_rd_we  = we2;

endmodule
